// File: rtl/udp_tx_chksum_output_ctrl.sv
// UDP TX checksum engine reader: strips the pseudo header, re-aligns payload onto the MAC beat and
// emits the UDP header with the final checksum. Optional counters: UDP_TX_CHKSUM_OUT_STATS_EN.

package udp_tx_chksum_output_ctrl_pkg;
    localparam int TRACKER_STATS_W = 64;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr;
endpackage

module udp_tx_chksum_output_ctrl
    import udp_tx_chksum_output_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = TRACKER_STATS_W,
    parameter int HOLD_BYTES = 20,
    parameter int USE_BYTES  = KEEP_WIDTH - HOLD_BYTES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         resp_tdata,
    input  logic [KEEP_WIDTH-1:0]         resp_tkeep,
    input  logic [USER_WIDTH-1:0]         resp_tuser,
    input  logic                          resp_tval,
    input  logic                          resp_tlast,
    output logic                          resp_trdy,
    input  logic [15:0]                   resp_csum,
    input  logic                          resp_csum_val,
    output logic                          resp_csum_rdy,
    output logic                          stream_dst_hdr_val,
    output logic [31:0]                   stream_dst_src_ip_addr,
    output logic [31:0]                   stream_dst_dst_ip_addr,
    output udp_pkt_hdr                    stream_dst_udp_hdr,
    output logic [USER_WIDTH-1:0]         stream_dst_timestamp,
    input  logic                          dst_stream_hdr_rdy,
    output logic                          stream_dst_data_val,
    output logic                          stream_dst_data_last,
    output logic [DATA_WIDTH-1:0]         stream_dst_data,
    output logic [$clog2(KEEP_WIDTH)-1:0] stream_dst_data_padbytes,
`ifdef UDP_TX_CHKSUM_OUT_STATS_EN
    output logic [31:0]                   pkt_cnt,
    output logic [31:0]                   byte_cnt,
`endif
    input  logic                          dst_stream_data_rdy
);

    localparam int          HOLD_W     = HOLD_BYTES * 8;
    localparam int          USE_W      = USE_BYTES * 8;
    localparam int          PAD_W      = $clog2(KEEP_WIDTH);
    localparam logic [15:0] BEAT_BYTES = 16'(KEEP_WIDTH);
    localparam logic [15:0] USE_LEN    = 16'(USE_BYTES);
    localparam logic [15:0] UDP_HDR_B  = 16'd8;

    typedef enum logic [1:0] {
        HDR_WAIT  = 2'd0,
        DATA      = 2'd1,
        DATA_LAST = 2'd2,
        CSUM_WAIT = 2'd3
    } state_t;

    // One's-complement finish; a zero result is sent as all-ones since zero means "no checksum".
    function automatic logic [15:0] final_csum(input logic [15:0] sum);
        logic [15:0] c;
        c = ~sum;
        if (c == 16'h0000) begin
            return 16'hFFFF;
        end else begin
            return c;
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [USE_W-1:0]        carry_r;
    logic [15:0]             rem_r;
    logic [31:0]             src_ip_r;
    logic [31:0]             dst_ip_r;
    udp_pkt_hdr              hdr_r;
    logic [USER_WIDTH-1:0]   ts_r;

    udp_pkt_hdr              hdr_in_s;
    logic [15:0]             len_in_s;
    logic                    out_last_s;
    logic                    beat0_take_s;
    logic                    data_take_s;
    logic                    hdr_take_s;
    logic                    unused_s;

    assign hdr_in_s   = udp_pkt_hdr'(resp_tdata[DATA_WIDTH-97 -: 64]);
    assign len_in_s   = hdr_in_s.length - UDP_HDR_B;
    assign out_last_s = (rem_r <= BEAT_BYTES);
    assign unused_s   = ^resp_tkeep;

    assign stream_dst_src_ip_addr = src_ip_r;
    assign stream_dst_dst_ip_addr = dst_ip_r;
    assign stream_dst_timestamp   = ts_r;
    assign stream_dst_udp_hdr     = '{src_port: hdr_r.src_port,
                                      dst_port: hdr_r.dst_port,
                                      length:   hdr_r.length,
                                      chksum:   final_csum(resp_csum)};

    // Next-state and handshake decode; data beats pass straight through while in DATA.
    always_comb begin
        state_nx_s               = state_r;
        resp_trdy                = 1'b0;
        resp_csum_rdy            = 1'b0;
        stream_dst_hdr_val       = 1'b0;
        stream_dst_data_val      = 1'b0;
        stream_dst_data_last     = 1'b0;
        stream_dst_data          = '0;
        stream_dst_data_padbytes = '0;
        beat0_take_s             = 1'b0;
        data_take_s              = 1'b0;
        hdr_take_s               = 1'b0;
        case (state_r)
            HDR_WAIT: begin
                resp_trdy    = 1'b1;
                beat0_take_s = resp_tval;
                if (resp_tval) begin
                    if (len_in_s == 16'd0) begin
                        state_nx_s = CSUM_WAIT;
                    end else if (len_in_s <= USE_LEN) begin
                        state_nx_s = DATA_LAST;
                    end else begin
                        state_nx_s = DATA;
                    end
                end else begin
                    state_nx_s = HDR_WAIT;
                end
            end
            DATA: begin
                resp_trdy            = dst_stream_data_rdy;
                stream_dst_data_val  = resp_tval;
                stream_dst_data      = {carry_r, resp_tdata[DATA_WIDTH-1 -: HOLD_W]};
                stream_dst_data_last = resp_tval & out_last_s;
                data_take_s          = resp_tval & dst_stream_data_rdy;
                if (resp_tval && out_last_s) begin
                    stream_dst_data_padbytes = PAD_W'(BEAT_BYTES - rem_r);
                end else begin
                    stream_dst_data_padbytes = '0;
                end
                // Beat that ends the stream with more than a beat still owed leaves a carry-only tail.
                if (data_take_s && out_last_s) begin
                    state_nx_s = CSUM_WAIT;
                end else if (data_take_s && resp_tlast) begin
                    state_nx_s = DATA_LAST;
                end else begin
                    state_nx_s = DATA;
                end
            end
            DATA_LAST: begin
                stream_dst_data_val      = 1'b1;
                stream_dst_data_last     = 1'b1;
                stream_dst_data          = {carry_r, {HOLD_W{1'b0}}};
                stream_dst_data_padbytes = PAD_W'(BEAT_BYTES - rem_r);
                if (dst_stream_data_rdy) begin
                    state_nx_s = CSUM_WAIT;
                end else begin
                    state_nx_s = DATA_LAST;
                end
            end
            CSUM_WAIT: begin
                stream_dst_hdr_val = resp_csum_val;
                resp_csum_rdy      = dst_stream_hdr_rdy;
                hdr_take_s         = resp_csum_val & dst_stream_hdr_rdy;
                if (hdr_take_s) begin
                    state_nx_s = HDR_WAIT;
                end else begin
                    state_nx_s = CSUM_WAIT;
                end
            end
            default: begin
                state_nx_s = HDR_WAIT;
            end
        endcase
    end

    // State, latched header fields, payload carry and remaining-byte count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= HDR_WAIT;
            carry_r  <= '0;
            rem_r    <= 16'd0;
            src_ip_r <= 32'd0;
            dst_ip_r <= 32'd0;
            hdr_r    <= '0;
            ts_r     <= '0;
        end else begin
            state_r <= state_nx_s;
            if (beat0_take_s) begin
                src_ip_r <= resp_tdata[DATA_WIDTH-1 -: 32];
                dst_ip_r <= resp_tdata[DATA_WIDTH-33 -: 32];
                hdr_r    <= hdr_in_s;
                ts_r     <= resp_tuser;
                carry_r  <= resp_tdata[USE_W-1:0];
                rem_r    <= len_in_s;
            end else if (data_take_s) begin
                carry_r <= resp_tdata[USE_W-1:0];
                rem_r   <= rem_r - BEAT_BYTES;
            end
        end
    end

`ifdef UDP_TX_CHKSUM_OUT_STATS_EN
    // Packet and payload-byte counters, stepped on each header handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= 32'd0;
            byte_cnt <= 32'd0;
        end else if (hdr_take_s) begin
            pkt_cnt  <= pkt_cnt + 32'd1;
            byte_cnt <= byte_cnt + {16'd0, hdr_r.length - UDP_HDR_B};
        end
    end
`endif

endmodule

// File: tb/tb_udp_tx_chksum_output_ctrl.sv
// Directed bench for udp_tx_chksum_output_ctrl: per-scenario tasks with hand-computed expectations.
`timescale 1ns/1ps
module tb_udp_tx_chksum_output_ctrl;
    import udp_tx_chksum_output_ctrl_pkg::*;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = TRACKER_STATS_W;
    localparam logic [31:0] SRC_IP = 32'hC0A8_0001;
    localparam logic [31:0] DST_IP = 32'h0A00_0002;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   resp_tdata = '0;
    logic [KW-1:0]   resp_tkeep = '0;
    logic [UW-1:0]   resp_tuser = '0;
    logic            resp_tval = 1'b0;
    logic            resp_tlast = 1'b0;
    logic            resp_trdy;
    logic [15:0]     resp_csum = 16'h0000;
    logic            resp_csum_val = 1'b0;
    logic            resp_csum_rdy;
    logic            stream_dst_hdr_val;
    logic [31:0]     stream_dst_src_ip_addr;
    logic [31:0]     stream_dst_dst_ip_addr;
    udp_pkt_hdr      stream_dst_udp_hdr;
    logic [UW-1:0]   stream_dst_timestamp;
    logic            dst_stream_hdr_rdy = 1'b0;
    logic            stream_dst_data_val;
    logic            stream_dst_data_last;
    logic [DW-1:0]   stream_dst_data;
    logic [4:0]      stream_dst_data_padbytes;
    logic            dst_stream_data_rdy = 1'b0;
`ifdef UDP_TX_CHKSUM_OUT_STATS_EN
    logic [31:0]     pkt_cnt;
    logic [31:0]     byte_cnt;
`endif

    udp_tx_chksum_output_ctrl dut (
        .clk(clk), .rst(rst),
        .resp_tdata(resp_tdata), .resp_tkeep(resp_tkeep), .resp_tuser(resp_tuser),
        .resp_tval(resp_tval), .resp_tlast(resp_tlast), .resp_trdy(resp_trdy),
        .resp_csum(resp_csum), .resp_csum_val(resp_csum_val), .resp_csum_rdy(resp_csum_rdy),
        .stream_dst_hdr_val(stream_dst_hdr_val),
        .stream_dst_src_ip_addr(stream_dst_src_ip_addr),
        .stream_dst_dst_ip_addr(stream_dst_dst_ip_addr),
        .stream_dst_udp_hdr(stream_dst_udp_hdr),
        .stream_dst_timestamp(stream_dst_timestamp),
        .dst_stream_hdr_rdy(dst_stream_hdr_rdy),
        .stream_dst_data_val(stream_dst_data_val),
        .stream_dst_data_last(stream_dst_data_last),
        .stream_dst_data(stream_dst_data),
        .stream_dst_data_padbytes(stream_dst_data_padbytes),
`ifdef UDP_TX_CHKSUM_OUT_STATS_EN
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
`endif
        .dst_stream_data_rdy(dst_stream_data_rdy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] in_data[$];
    logic [KW-1:0] in_keep[$];
    bit            in_last[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    logic [4:0]    got_pad[$];
    udp_pkt_hdr    got_hdr;
    logic [31:0]   got_src;
    logic [31:0]   got_dst;
    logic [UW-1:0] got_ts;
    int            beats_at_hdr;
    int            trdy_bad;
    bit            timed_out;

    function automatic logic [7:0] pbyte(input int seed, input int i);
        return 8'(seed * 7 + i + 1);
    endfunction

    function automatic logic [KW-1:0] keep_of(input int n);
        logic [KW-1:0] ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

    // Engine stream for a payload of len bytes, plus the expected MAC beats (payload MSB-first, zero tail).
    task automatic build_pkt(input int len, input int seed);
        logic [DW-1:0] b;
        int nb;
        in_data.delete(); in_keep.delete(); in_last.delete(); exp_data.delete();
        b = '0;
        b[DW-1 -: 32]  = SRC_IP;
        b[DW-33 -: 32] = DST_IP;
        b[DW-65 -: 32] = {8'h00, 8'h11, 16'(len + 8)};
        b[DW-97 -: 64] = {16'h1234, 16'h5678, 16'(len + 8), 16'h0000};
        for (int i = 0; i < 12; i++) if (i < len) b[95 - 8*i -: 8] = pbyte(seed, i);
        in_data.push_back(b);
        in_keep.push_back(keep_of(20 + ((len < 12) ? len : 12)));
        nb = (len <= 12) ? 0 : (len - 12 + 31) / 32;
        for (int j = 0; j < nb; j++) begin
            b = '0;
            for (int i = 0; i < 32; i++)
                if (12 + 32*j + i < len) b[DW-1 - 8*i -: 8] = pbyte(seed, 12 + 32*j + i);
            in_data.push_back(b);
            in_keep.push_back(keep_of((len - 12 - 32*j > 32) ? 32 : len - 12 - 32*j));
        end
        for (int j = 0; j < in_data.size(); j++) in_last.push_back(j == in_data.size() - 1);
        for (int k = 0; k < (len + 31) / 32; k++) begin
            b = '0;
            for (int i = 0; i < 32; i++) if (32*k + i < len) b[DW-1 - 8*i -: 8] = pbyte(seed, 32*k + i);
            exp_data.push_back(b);
        end
    endtask

    // Drives the prepared stream with the sum offered from the start and records every output handshake.
    task automatic run_pkt(input logic [15:0] csum, input logic [UW-1:0] ts, input bit bp);
        int ib;
        bit done;
        got_data.delete(); got_last.delete(); got_pad.delete();
        ib = 0; done = 1'b0; trdy_bad = 0; beats_at_hdr = -1; timed_out = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (ib < in_data.size()) begin
                resp_tval = 1'b1; resp_tdata = in_data[ib]; resp_tkeep = in_keep[ib]; resp_tlast = in_last[ib];
            end else begin
                resp_tval = 1'b0; resp_tdata = '0; resp_tkeep = '0; resp_tlast = 1'b0;
            end
            resp_tuser = ts; resp_csum = csum; resp_csum_val = 1'b1;
            dst_stream_data_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dst_stream_hdr_rdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (resp_tval && ib > 0 && resp_trdy !== dst_stream_data_rdy) trdy_bad++;
            if (stream_dst_data_val && dst_stream_data_rdy) begin
                got_data.push_back(stream_dst_data);
                got_last.push_back(stream_dst_data_last);
                got_pad.push_back(stream_dst_data_padbytes);
            end
            if (stream_dst_hdr_val && dst_stream_hdr_rdy) begin
                got_hdr = stream_dst_udp_hdr; got_src = stream_dst_src_ip_addr;
                got_dst = stream_dst_dst_ip_addr; got_ts = stream_dst_timestamp;
                beats_at_hdr = got_data.size(); done = 1'b1;
            end
            if (resp_tval && resp_trdy) ib++;
        end
        timed_out = !done;
        @(negedge clk);
        resp_tval = 1'b0; resp_tlast = 1'b0; resp_csum_val = 1'b0;
        dst_stream_data_rdy = 1'b0; dst_stream_hdr_rdy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (resp_trdy !== 1'b1) begin errors++; $display("FAIL reset_trdy: got %0b want 1", resp_trdy); end
        checks++; if (stream_dst_data_val !== 1'b0) begin errors++; $display("FAIL reset_data_val: got %0b want 0", stream_dst_data_val); end
        checks++; if (stream_dst_hdr_val !== 1'b0) begin errors++; $display("FAIL reset_hdr_val: got %0b want 0", stream_dst_hdr_val); end
        checks++; if (resp_csum_rdy !== 1'b0) begin errors++; $display("FAIL reset_csum_rdy: got %0b want 0", resp_csum_rdy); end
        checks++; if (stream_dst_data_padbytes !== 5'd0) begin errors++; $display("FAIL reset_pad: got %0d want 0", stream_dst_data_padbytes); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_len0;
        build_pkt(0, 1);
        run_pkt(16'h1234, 64'h0000_0000_0000_0011, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL len0_timeout: got %0b want 0", timed_out); end
        checks++; if (got_data.size() !== 0) begin errors++; $display("FAIL len0_beats: got %0d want 0", got_data.size()); end
        checks++; if (got_hdr.chksum !== 16'hEDCB) begin errors++; $display("FAIL len0_chksum: got %h want edcb", got_hdr.chksum); end
        checks++; if (got_hdr.length !== 16'd8) begin errors++; $display("FAIL len0_length: got %0d want 8", got_hdr.length); end
        checks++; if (got_src !== SRC_IP || got_dst !== DST_IP) begin errors++; $display("FAIL len0_ips: got %h %h want %h %h", got_src, got_dst, SRC_IP, DST_IP); end
        checks++; if (got_ts !== 64'h11) begin errors++; $display("FAIL len0_ts: got %h want 11", got_ts); end
    endtask

    task automatic test_single_beat;
        build_pkt(12, 2);
        run_pkt(16'h0F0F, 64'h22, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL len12_timeout: got %0b want 0", timed_out); end
        checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL len12_beats: got %0d want 1", got_data.size()); end
        if (got_data.size() > 0) begin
            checks++; if (got_data[0][DW-1 -: 96] !== in_data[0][95:0]) begin errors++; $display("FAIL len12_bytes: got %h want %h", got_data[0][DW-1 -: 96], in_data[0][95:0]); end
            checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL len12_last: got %0b want 1", got_last[0]); end
            checks++; if (got_pad[0] !== 5'd20) begin errors++; $display("FAIL len12_pad: got %0d want 20", got_pad[0]); end
        end
        checks++; if (got_hdr.chksum !== 16'hF0F0) begin errors++; $display("FAIL len12_chksum: got %h want f0f0", got_hdr.chksum); end
        checks++; if (beats_at_hdr !== 1) begin errors++; $display("FAIL len12_hdr_order: got %0d want 1", beats_at_hdr); end
    endtask

    task automatic test_data_last;
        build_pkt(44, 3);
        run_pkt(16'h0001, 64'h33, 1'b0);
        checks++; if (got_data.size() !== 2) begin errors++; $display("FAIL len44_beats: got %0d want 2", got_data.size()); end
        for (int k = 0; k < 2 && k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== exp_data[k]) begin errors++; $display("FAIL len44_data%0d: got %h want %h", k, got_data[k], exp_data[k]); end
            checks++; if (got_last[k] !== (k == 1)) begin errors++; $display("FAIL len44_last%0d: got %0b want %0b", k, got_last[k], k == 1); end
            checks++; if (got_pad[k] !== ((k == 1) ? 5'd20 : 5'd0)) begin errors++; $display("FAIL len44_pad%0d: got %0d", k, got_pad[k]); end
        end
        checks++; if (got_hdr.chksum !== 16'hFFFE) begin errors++; $display("FAIL len44_chksum: got %h want fffe", got_hdr.chksum); end
        checks++; if (got_hdr.length !== 16'd52) begin errors++; $display("FAIL len44_length: got %0d want 52", got_hdr.length); end
    endtask

    task automatic test_aligned;
        build_pkt(32, 4);
        run_pkt(16'h4321, 64'h44, 1'b0);
        checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL len32_beats: got %0d want 1", got_data.size()); end
        if (got_data.size() > 0) begin
            checks++; if (got_data[0] !== exp_data[0]) begin errors++; $display("FAIL len32_data: got %h want %h", got_data[0], exp_data[0]); end
            checks++; if (got_last[0] !== 1'b1 || got_pad[0] !== 5'd0) begin errors++; $display("FAIL len32_lastpad: got %0b/%0d want 1/0", got_last[0], got_pad[0]); end
        end
        checks++; if (got_hdr.chksum !== 16'hBCDE) begin errors++; $display("FAIL len32_chksum: got %h want bcde", got_hdr.chksum); end
        build_pkt(64, 5);
        run_pkt(16'h8000, 64'h45, 1'b0);
        checks++; if (got_data.size() !== 2) begin errors++; $display("FAIL len64_beats: got %0d want 2", got_data.size()); end
        for (int k = 0; k < 2 && k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== exp_data[k]) begin errors++; $display("FAIL len64_data%0d: got %h want %h", k, got_data[k], exp_data[k]); end
            checks++; if (got_last[k] !== (k == 1) || got_pad[k] !== 5'd0) begin errors++; $display("FAIL len64_lastpad%0d: got %0b/%0d", k, got_last[k], got_pad[k]); end
        end
        checks++; if (got_hdr.chksum !== 16'h7FFF) begin errors++; $display("FAIL len64_chksum: got %h want 7fff", got_hdr.chksum); end
    endtask

    task automatic test_backpressure;
        build_pkt(100, 6);
        run_pkt(16'hFFFF, 64'h66, 1'b1);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %0b want 0", timed_out); end
        checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL bp_beats: got %0d want 4", got_data.size()); end
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== exp_data[k]) begin errors++; $display("FAIL bp_data%0d: got %h want %h", k, got_data[k], exp_data[k]); end
            checks++; if (got_last[k] !== (k == 3) || got_pad[k] !== ((k == 3) ? 5'd28 : 5'd0)) begin errors++; $display("FAIL bp_lastpad%0d: got %0b/%0d", k, got_last[k], got_pad[k]); end
        end
        checks++; if (trdy_bad !== 0) begin errors++; $display("FAIL bp_trdy_track: got %0d mismatching cycles want 0", trdy_bad); end
        checks++; if (got_hdr.chksum !== 16'hFFFF) begin errors++; $display("FAIL bp_chksum: got %h want ffff", got_hdr.chksum); end
        checks++; if (beats_at_hdr !== 4) begin errors++; $display("FAIL bp_hdr_order: got %0d want 4", beats_at_hdr); end
        build_pkt(5, 7);
        run_pkt(16'h0000, 64'h67, 1'b1);
        checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL bp5_beats: got %0d want 1", got_data.size()); end
        if (got_data.size() > 0) begin
            checks++; if (got_data[0] !== exp_data[0]) begin errors++; $display("FAIL bp5_data: got %h want %h", got_data[0], exp_data[0]); end
            checks++; if (got_pad[0] !== 5'd27) begin errors++; $display("FAIL bp5_pad: got %0d want 27", got_pad[0]); end
        end
        checks++; if (got_hdr.chksum !== 16'hFFFF) begin errors++; $display("FAIL bp5_chksum: got %h want ffff", got_hdr.chksum); end
    endtask

    task automatic test_mid_reset;
        build_pkt(44, 9);
        @(negedge clk);
        resp_tval = 1'b1; resp_tdata = in_data[0]; resp_tkeep = in_keep[0]; resp_tlast = 1'b0;
        dst_stream_data_rdy = 1'b0; resp_csum_val = 1'b0;
        @(negedge clk);
        resp_tdata = in_data[1]; resp_tkeep = in_keep[1]; resp_tlast = 1'b1;
        #1;
        checks++; if (stream_dst_data_val !== 1'b1 || resp_trdy !== 1'b0) begin errors++; $display("FAIL mrst_stall: got val=%0b trdy=%0b want 1/0", stream_dst_data_val, resp_trdy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (stream_dst_data_val !== 1'b0) begin errors++; $display("FAIL mrst_data_val: got %0b want 0", stream_dst_data_val); end
        checks++; if (resp_trdy !== 1'b1) begin errors++; $display("FAIL mrst_trdy: got %0b want 1", resp_trdy); end
        checks++; if (stream_dst_hdr_val !== 1'b0 || resp_csum_rdy !== 1'b0) begin errors++; $display("FAIL mrst_hdr: got %0b/%0b want 0/0", stream_dst_hdr_val, resp_csum_rdy); end
        @(negedge clk);
        rst = 1'b0; resp_tval = 1'b0; resp_tlast = 1'b0;
        build_pkt(44, 10);
        run_pkt(16'hA5A5, 64'h77, 1'b0);
        checks++; if (got_data.size() !== 2) begin errors++; $display("FAIL mrst_beats: got %0d want 2", got_data.size()); end
        for (int k = 0; k < 2 && k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== exp_data[k]) begin errors++; $display("FAIL mrst_data%0d: got %h want %h", k, got_data[k], exp_data[k]); end
        end
        checks++; if (got_hdr.chksum !== 16'h5A5A) begin errors++; $display("FAIL mrst_chksum: got %h want 5a5a", got_hdr.chksum); end
        checks++; if (got_ts !== 64'h77) begin errors++; $display("FAIL mrst_ts: got %h want 77", got_ts); end
    endtask

    initial begin
        test_reset();
        test_len0();
        test_single_beat();
        test_data_last();
        test_aligned();
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
